// File: rtl/bcd_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_share_pkg
//  Description : Shared defaults, FSM state type and datapath constants for
//                the time-shared binary-to-BCD scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_share_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_NREQ  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A BCD column at or above this value must be corrected before doubling.
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage : bcd_share_pkg
`default_nettype wire

// File: rtl/bcd_share_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns the first active
//                request at or after rr_ptr, wrapping at NREQ.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import bcd_share_pkg::*;
#(
    parameter  int NREQ = DEFAULT_NREQ,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = IDW + 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] sel,
    output logic [IDW-1:0]  sel_idx,
    output logic            any
);

    // Walk the requesters circularly from rr_ptr; the first active one wins.
    always_comb begin
        logic [CW-1:0] cand;
        sel     = '0;
        sel_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int off = 0; off < NREQ; off++) begin
            // One spare bit keeps rr_ptr + off exact before the modulo fold.
            cand = {1'b0, rr_ptr} + CW'(off);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!any && req[cand[IDW-1:0]]) begin
                any                  = 1'b1;
                sel[cand[IDW-1:0]]   = 1'b1;
                sel_idx              = cand[IDW-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bcd_share_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_share_scheduler
//  Description : Shares one sequential double-dabble engine between NREQ
//                requesters. Round-robin grant, WIDTH shift cycles, then a
//                one-cycle done pulse with hundreds/tens/ones and the owner.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_share_scheduler
    import bcd_share_pkg::*;
#(
    parameter  int NREQ  = DEFAULT_NREQ,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   value,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          result_id,
    output logic [3:0]              hundreds,
    output logic [3:0]              tens,
    output logic [3:0]              ones
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SRW  = 12 + WIDTH;

    state_t          state;
    state_t          state_nxt;

    logic [NREQ-1:0] arb_sel;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic [WIDTH-1:0] operand;
    logic [3:0]      acc_h;
    logic [3:0]      acc_t;
    logic [3:0]      acc_o;
    logic [3:0]      adj_t;
    logic [3:0]      adj_o;
    logic [SRW-1:0]  shifted;
    logic [CNTW-1:0] bit_cnt;
    logic            last_shift;

    rr_arbiter #(
        .NREQ    (NREQ)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .sel     (arb_sel),
        .sel_idx (arb_idx),
        .any     (arb_any)
    );

    assign last_shift = (state == SHIFT) && (bit_cnt == '0);

    // One double-dabble step: correct tens/ones, then shift the whole chain.
    // The hundreds column is left uncorrected so it accumulates value/100 in
    // plain binary; that yields 10 for 1000..1023 instead of spilling into a
    // thousands digit, and is identical to BCD for anything below 1000.
    always_comb begin
        adj_o   = (acc_o >= ADD3_THRESH) ? (acc_o + 4'd3) : acc_o;
        adj_t   = (acc_t >= ADD3_THRESH) ? (acc_t + 4'd3) : acc_t;
        shifted = {acc_h, adj_t, adj_o, operand} << 1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: IDLE grants, SHIFT runs WIDTH steps, DONE lasts a cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the grant is issued in the IDLE cycle that wins arbitration,
    // so busy covers grant cycle, all shift cycles and the done cycle.
    always_comb begin
        gnt  = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                if (reset_n && arb_any) begin
                    gnt  = arb_sel;
                    busy = 1'b1;
                end
            end
            SHIFT:   busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Conversion datapath: load on grant, then one shift per SHIFT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand   <= '0;
            acc_h     <= '0;
            acc_t     <= '0;
            acc_o     <= '0;
            bit_cnt   <= '0;
            grant_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        operand   <= value[arb_idx*WIDTH +: WIDTH];
                        acc_h     <= '0;
                        acc_t     <= '0;
                        acc_o     <= '0;
                        bit_cnt   <= CNTW'(WIDTH - 1);
                        grant_idx <= arb_idx;
                    end
                end
                SHIFT: begin
                    {acc_h, acc_t, acc_o, operand} <= shifted;
                    bit_cnt <= bit_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result and pointer update on the final shift, so the digits are already
    // stable during the done cycle and hold until the next conversion ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hundreds  <= '0;
            tens      <= '0;
            ones      <= '0;
            result_id <= '0;
            rr_ptr    <= '0;
        end else if (last_shift) begin
            hundreds  <= shifted[SRW-1 -: 4];
            tens      <= shifted[SRW-5 -: 4];
            ones      <= shifted[SRW-9 -: 4];
            result_id <= grant_idx;
            rr_ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : (grant_idx + 1'b1);
        end
    end

endmodule : bcd_share_scheduler
`default_nettype wire

// File: tb/tb_bcd_share_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_share_scheduler
//  Description : Randomised scoreboard bench for bcd_share_scheduler. A
//                reference model predicts grants and decimal digits using
//                plain division; a monitor pops and checks on done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_share_scheduler;

    localparam int NREQ  = 3;
    localparam int WIDTH = 10;
    localparam int IDW   = $clog2(NREQ);
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] value;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        result_id;
    logic [3:0]            hundreds;
    logic [3:0]            tens;
    logic [3:0]            ones;

    bcd_share_scheduler #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .value     (value),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .result_id (result_id),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int h;
        int t;
        int o;
        int due;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // reference-model state
    int m_ptr      = 0;
    int next_free  = 0;
    int busy_until = -1;
    int waits2     = 0;

    // last result the monitor expects to be held on the outputs
    int hold_id = 0;
    int hold_h  = 0;
    int hold_t  = 0;
    int hold_o  = 0;

    logic [NREQ-1:0] seen_gnt;
    logic [NREQ-1:0] drop_mask;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: whenever the engine is free and someone requests, the
    // winner is the first active requester counting up from the pointer.
    initial begin : ref_model
        int win;
        int v;
        logic [NREQ-1:0] exp_gnt;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb.delete();
                m_ptr      = 0;
                next_free  = 0;
                busy_until = -1;
                waits2     = 0;
            end else begin
                exp_gnt = '0;
                if (cyc >= next_free && req != '0) begin
                    win = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        int j;
                        j = (m_ptr + k) % NREQ;
                        if (win < 0 && req[j[IDW-1:0]]) win = j;
                    end
                    v     = int'(value[win*WIDTH +: WIDTH]);
                    e.id  = win;
                    e.h   = v / 100;
                    e.t   = (v / 10) % 10;
                    e.o   = v % 10;
                    e.due = cyc + WIDTH + 1;
                    sb.push_back(e);
                    exp_gnt[win[IDW-1:0]] = 1'b1;
                    busy_until = cyc + WIDTH + 1;
                    next_free  = cyc + WIDTH + 2;
                    m_ptr      = (win + 1) % NREQ;
                    if (win == NREQ - 1) begin
                        check("fair_wait_ok", int'(waits2 <= NREQ - 1), 1);
                        waits2 = 0;
                    end else if (req[NREQ-1]) begin
                        waits2++;
                    end else begin
                        waits2 = 0;
                    end
                end
                check("gnt", int'(gnt), int'(exp_gnt));
                check("busy", int'(busy), (cyc <= busy_until) ? 1 : 0);
            end
        end
    end

    // Monitor: pops the scoreboard on done and checks that results hold.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_id = 0;
                hold_h  = 0;
                hold_t  = 0;
                hold_o  = 0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("result_id", int'(result_id), e.id);
                    check("hundreds", int'(hundreds), e.h);
                    check("tens", int'(tens), e.t);
                    check("ones", int'(ones), e.o);
                    hold_id = e.id;
                    hold_h  = e.h;
                    hold_t  = e.t;
                    hold_o  = e.o;
                end
            end else begin
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    check("done_missing", int'(done), 1);
                    e = sb.pop_front();
                end
                check("hold", int'({result_id, hundreds, tens, ones}),
                      (hold_id << 12) | (hold_h << 8) | (hold_t << 4) | hold_o);
            end
        end
    end

    // One clock: remember the grant, then let granted requesters drop req.
    task automatic step();
        @(negedge clk);
        seen_gnt = gnt;
        @(posedge clk);
        #2;
        req = req & ~(seen_gnt & drop_mask);
    endtask

    task automatic raise(input int k, input int v);
        value[k*WIDTH +: WIDTH] = v[WIDTH-1:0];
        req[k] = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || cyc < next_free || req != '0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("drain_timeout", n, budget - 1);
    endtask

    task automatic wait_gnt(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (seen_gnt == '0 && n < budget);
        if (seen_gnt == '0) check("gnt_timeout", int'(seen_gnt), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"}, int'(gnt), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_result_id"}, int'(result_id), 0);
        check({tag, "_hundreds"}, int'(hundreds), 0);
        check({tag, "_tens"}, int'(tens), 0);
        check({tag, "_ones"}, int'(ones), 0);
    endtask

    task automatic reset_pulse(input string tag);
        reset_n = 1'b0;
        #1;
        check_reset(tag);
        req = '0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    function automatic int pick_val();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 999;
            2:       return 1000;
            3:       return MAXV;
            default: return int'($urandom_range(0, MAXV));
        endcase
    endfunction

    initial begin : stimulus
        int turn;
        req       = '0;
        value     = '0;
        drop_mask = '1;
        seen_gnt  = '0;

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #2 reset_n = 1'b1;

        // single conversion from reset
        raise(0, 123);
        wait_idle(40);

        // conversion boundaries
        raise(1, 0);
        wait_idle(40);
        raise(2, 999);
        wait_idle(40);
        raise(0, 1023);
        wait_idle(40);

        // all three held: round-robin from pointer 0
        reset_pulse("rst");
        drop_mask = '0;
        raise(0, 7);
        raise(1, 58);
        raise(2, 640);
        repeat (12 * 4) step();
        req       = '0;
        drop_mask = '1;
        wait_idle(40);

        // operand changes right after the grant must not affect the result
        raise(0, 500);
        wait_gnt(20);
        value[0 +: WIDTH] = 10'd42;
        wait_idle(40);

        // reset in the middle of a conversion
        raise(2, pick_val());
        wait_gnt(20);
        repeat (4) step();
        reset_pulse("mid");
        raise(1, 321);
        wait_idle(40);

        // requester 2 holds while 0 and 1 alternate
        drop_mask = 3'b011;
        raise(2, pick_val());
        turn = 0;
        for (int i = 0; i < 120; i++) begin
            if (!req[0] && !req[1]) begin
                raise(turn, pick_val());
                turn = 1 - turn;
            end
            step();
        end
        req       = '0;
        drop_mask = '1;
        wait_idle(40);

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req[k] && $urandom_range(0, 3) == 0) begin
                    raise(k, pick_val());
                end else if ($urandom_range(0, 7) == 0) begin
                    value[k*WIDTH +: WIDTH] = WIDTH'(pick_val());
                end
            end
            if ($urandom_range(0, 31) == 0) drop_mask = NREQ'($urandom);
            step();
        end
        req       = '0;
        drop_mask = '1;
        wait_idle(60);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bcd_share_scheduler
`default_nettype wire

// File: doc/bcd_share_scheduler.md
# bcd_share_scheduler

Time-multiplexes one sequential shift-add-3 (double-dabble) binary-to-BCD engine between several display requesters (score, high score, level counter) in the game's score/HUD path. Arbitrates requests round-robin, converts the granted 10-bit value over WIDTH clock cycles, and returns hundreds/tens/ones digits tagged with the requester index. These results feed the seven-segment/HUD digit registers.

## Interface
- NREQ, 3, number of requesters (2..8)
- WIDTH, 10, binary operand width; max value 2^WIDTH-1 (1023 at default)
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  request level per requester
- value  in  NREQ*WIDTH  flattened operands; requester k occupies bits [k*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- busy  out  1  high from the grant cycle until the done cycle inclusive
- done  out  1  one-cycle pulse, result valid
- result_id  out  $clog2(NREQ)  index of the requester the result belongs to
- hundreds  out  4  BCD hundreds digit (may be 10 for inputs 1000..1023)
- tens  out  4  BCD tens digit
- ones  out  4  BCD ones digit

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if any req bit is high, select the first requester at or after rr_ptr (wrapping at NREQ). Assert gnt for that requester. Capture its value slice into the shift register, clear the BCD accumulator, load the bit counter with WIDTH-1, and go to SHIFT. If no req bit is high, stay in IDLE.
- SHIFT, once per cycle:
  - Each 4-bit column that is >= 5 gets +3.
  - Then shift {hundreds,tens,ones,operand} left one bit, MSB of the operand first.
  - After WIDTH shifts, go to DONE.
- DONE:
  - Register the accumulator into hundreds/tens/ones and the granted index into result_id.
  - Pulse done.
  - Set rr_ptr to granted index + 1, modulo NREQ.
  - Return to IDLE.
- Requesters:
  - Each requester drops req on seeing its gnt.
  - A requester may re-raise req at any time.
  - A req still high in IDLE is simply arbitrated again.
- value is sampled only in the grant cycle. Later changes do not affect the conversion in flight.
- hundreds/tens/ones/result_id hold their last value until the next done.
- The hundreds column is not saturated. Inputs 1000..1023 yield hundreds = 10, which the consumer blanks or clamps.

## Timing
- Reset (async assert, sync deassert by system):
  - state = IDLE, rr_ptr = 0.
  - gnt = 0, busy = 0, done = 0.
  - result_id = 0, hundreds = tens = ones = 0.
- Grant latency: req high in IDLE at edge N → gnt and busy high during cycle N+1.
- Conversion: WIDTH SHIFT cycles, then a DONE cycle. done is high exactly WIDTH+1 cycles after the gnt cycle; for example, WIDTH=10 gives done 11 cycles after gnt.
- Back-to-back throughput: one conversion per WIDTH+2 cycles.
- done and the next gnt never coincide. IDLE always occupies at least one cycle.
- Simultaneous requests: round-robin from rr_ptr. No requester waits more than NREQ-1 conversions.
- Reset mid-conversion: the conversion is abandoned, all outputs return to reset values, and no done is issued.
- A req for the granted requester that stays high through DONE is treated as a new request.

## Structure
- Shared package bcd_share_pkg holds:
  - default WIDTH and NREQ
  - the state typedef {IDLE, SHIFT, DONE}
  - the constant ADD3_THRESH = 5
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: req, rr_ptr
  - outputs: one-hot sel, sel_idx, any
  - purely combinational
  - instantiated once
- The shift/add-3 datapath and the FSM stay in bcd_share_scheduler.

## Test plan
- Reset then req=3'b001, value0=10'd123 → gnt=001 one cycle; done 11 cycles later; result_id=0, hundreds/tens/ones = 1/2/3; busy high for 12 cycles.
- Conversion boundaries: value 0 gives 0/0/0; 999 gives 9/9/9; 1023 gives hundreds=10, tens=2, ones=3.
- req=3'b111 held continuously, values 7/58/640 → grants in order 001, 010, 100, 001; results 0/0/7, 0/5/8, 6/4/0; spacing 12 cycles.
- value0 changes from 500 to 42 the cycle after gnt → result still 5/0/0.
- reset_n pulled low at SHIFT cycle 5 → all outputs zero immediately, no done; after release with req=010 and value1=321, gnt=010 and result 3/2/1 with result_id=1.
- Requester 2 holds req while requesters 0 and 1 request alternately → requester 2 is granted within every 3 conversions (fairness check).
